// File: rtl/kd_pkg.sv
// Shared constants and types for the Kyber/Dilithium NTT butterfly datapath.
package kd_pkg;

  localparam int unsigned LATENCY = 4;

  // Moduli and Barrett constants (M = floor(2^SHIFT / q))
  localparam int unsigned Kq     = 3329;
  localparam int unsigned Dq     = 8380417;
  localparam int unsigned Km     = 5039;
  localparam int unsigned Dm     = 8396807;
  localparam int unsigned KShift = 24;
  localparam int unsigned DShift = 46;

  // Widths of products, Barrett constants and reduced results per mode
  localparam int unsigned KPW = 24;
  localparam int unsigned DPW = 46;
  localparam int unsigned KMW = 13;
  localparam int unsigned DMW = 24;
  localparam int unsigned KOW = 12;
  localparam int unsigned DOW = 23;

  typedef enum logic {
    MODE_KYBER     = 1'b0,
    MODE_DILITHIUM = 1'b1
  } kd_mode_e;

  // Per-beat side information that travels alongside the arithmetic
  typedef struct packed {
    kd_mode_e    mode;
    logic        bypass;
    logic [23:0] a;
  } kd_ctrl_t;

endpackage

// File: rtl/barrett_red.sv
// Pipelined Barrett reduction of one product: quotient estimate, then two
// conditional subtracts. The final subtract is combinational so the parent
// can fold it into its output mux before the last register.
module barrett_red #(
  parameter int unsigned Q     = 3329,
  parameter int unsigned M     = 5039,
  parameter int unsigned SHIFT = 24,
  parameter int unsigned PW    = 24,
  parameter int unsigned MW    = 13,
  parameter int unsigned OW    = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en2_i,
  input  logic          en3_i,
  input  logic [PW-1:0] p_i,
  output logic [OW-1:0] res_o
);

  // The remainder estimate lies in [0, 3Q), so OW+2 bits hold it exactly and
  // the subtract can be done modulo 2^RW on the low bits only.
  localparam int unsigned TW = PW + MW - SHIFT;
  localparam int unsigned RW = OW + 2;
  localparam logic [MW-1:0] MC = MW'(M);
  localparam logic [RW-1:0] QR = RW'(Q);

  logic [TW-1:0] t_d, t_q;
  logic [RW-1:0] pLow_q;
  logic [RW-1:0] tQ, rRaw, r_d, r_q;

  // Quotient estimate from the full-width product p*M, no truncation before the shift
  always_comb begin
    t_d = TW'(({{MW{1'b0}}, p_i} * {{PW{1'b0}}, MC}) >> SHIFT);
  end

  // Stage 2: register quotient estimate and the low bits of p needed for the remainder
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_q    <= '0;
      pLow_q <= '0;
    end else if (en2_i) begin
      t_q    <= t_d;
      pLow_q <= p_i[RW-1:0];
    end
  end

  // Remainder p - t*Q followed by the first conditional subtract
  always_comb begin
    tQ   = RW'(t_q) * QR;
    rRaw = pLow_q - tQ;
    r_d  = (rRaw >= QR) ? (rRaw - QR) : rRaw;
  end

  // Stage 3: register the partially reduced remainder
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else if (en3_i) begin
      r_q <= r_d;
    end
  end

  // Second conditional subtract, consumed by the parent's stage-4 mux
  always_comb begin
    res_o = OW'((r_q >= QR) ? (r_q - QR) : r_q);
  end

endmodule

// File: rtl/kd_modmul.sv
// Dual-mode pipelined modular multiplier (twiddle half of the NTT butterfly).
// Kyber: two 12-bit lanes mod 3329. Dilithium: one 23-bit word mod 8380417.
module kd_modmul
  import kd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        KD_mode,
  input  logic        bypass,
  input  logic        in_valid,
  input  logic [23:0] mul_a,
  input  logic [23:0] mul_w,
  output logic        out_valid,
  output logic [23:0] mul_p
);

  logic [LATENCY:0] vld_q;
  kd_ctrl_t         ctrl_q [0:3];
  logic [23:0]      w0_q;
  logic [KPW-1:0]   pH_d, pL_d, pH_q, pL_q;
  logic [DPW-1:0]   pD_d, pD_q;
  logic [KOW-1:0]   resH, resL;
  logic [DOW-1:0]   resD;
  logic [23:0]      mulP_d, mulP_q;

  // Valid shift register: every beat emerges exactly LATENCY edges after sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-1:0], in_valid};
    end
  end

  // Mode/bypass/operand-a pipeline; each stage loads only behind a valid beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) ctrl_q[i] <= '0;
      w0_q <= '0;
    end else begin
      if (in_valid) begin
        ctrl_q[0] <= '{mode: kd_mode_e'(KD_mode), bypass: bypass, a: mul_a};
        w0_q      <= mul_w;
      end
      for (int i = 1; i < 4; i++) begin
        if (vld_q[i-1]) ctrl_q[i] <= ctrl_q[i-1];
      end
    end
  end

  // Lane and word products; operands are zero-extended so nothing truncates
  always_comb begin
    pH_d = {12'b0, ctrl_q[0].a[23:12]} * {12'b0, w0_q[23:12]};
    pL_d = {12'b0, ctrl_q[0].a[11:0]}  * {12'b0, w0_q[11:0]};
    pD_d = {23'b0, ctrl_q[0].a[22:0]}  * {23'b0, w0_q[22:0]};
  end

  // Stage 1: register the products
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pH_q <= '0;
      pL_q <= '0;
      pD_q <= '0;
    end else if (vld_q[0]) begin
      pH_q <= pH_d;
      pL_q <= pL_d;
      pD_q <= pD_d;
    end
  end

  barrett_red #(.Q(Kq), .M(Km), .SHIFT(KShift), .PW(KPW), .MW(KMW), .OW(KOW)) uRedHigh (
    .clk_i(clk), .rst_ni(rst), .en2_i(vld_q[1]), .en3_i(vld_q[2]), .p_i(pH_q), .res_o(resH)
  );

  barrett_red #(.Q(Kq), .M(Km), .SHIFT(KShift), .PW(KPW), .MW(KMW), .OW(KOW)) uRedLow (
    .clk_i(clk), .rst_ni(rst), .en2_i(vld_q[1]), .en3_i(vld_q[2]), .p_i(pL_q), .res_o(resL)
  );

  barrett_red #(.Q(Dq), .M(Dm), .SHIFT(DShift), .PW(DPW), .MW(DMW), .OW(DOW)) uRedDil (
    .clk_i(clk), .rst_ni(rst), .en2_i(vld_q[1]), .en3_i(vld_q[2]), .p_i(pD_q), .res_o(resD)
  );

  // Output select by the beat's own mode and bypass flags
  always_comb begin
    mulP_d = {resH, resL};
    if (ctrl_q[3].bypass) begin
      mulP_d = (ctrl_q[3].mode == MODE_DILITHIUM) ? {1'b0, ctrl_q[3].a[22:0]} : ctrl_q[3].a;
    end else if (ctrl_q[3].mode == MODE_DILITHIUM) begin
      mulP_d = {1'b0, resD};
    end
  end

  // Stage 4: output register, held when no valid beat arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mulP_q <= '0;
    end else if (vld_q[3]) begin
      mulP_q <= mulP_d;
    end
  end

  assign out_valid = vld_q[LATENCY];
  assign mul_p     = mulP_q;

endmodule

// File: tb/tb_kd_modmul.sv
// Scoreboard bench for kd_modmul: directed vectors, mode interleave, bypass,
// mid-stream reset and a random sweep against a direct a*w mod q model.
module tb_kd_modmul;

  logic        clk;
  logic        rst;
  logic        KD_mode;
  logic        bypass;
  logic        in_valid;
  logic [23:0] mul_a;
  logic [23:0] mul_w;
  logic        out_valid;
  logic [23:0] mul_p;

  typedef struct {
    logic [23:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] lastP = '0;

  kd_modmul dut (
    .clk(clk), .rst(rst), .KD_mode(KD_mode), .bypass(bypass), .in_valid(in_valid),
    .mul_a(mul_a), .mul_w(mul_w), .out_valid(out_valid), .mul_p(mul_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference result computed with plain modulo arithmetic
  function automatic logic [23:0] modelP(logic mode, logic byp, logic [23:0] a, logic [23:0] w);
    longint unsigned ph, pl, pd;
    logic [23:0] r;
    if (byp) begin
      r = a;
      if (mode) r[23] = 1'b0;
      return r;
    end
    if (mode) begin
      pd = a[22:0];
      pd = (pd * w[22:0]) % 8380417;
      return {1'b0, pd[22:0]};
    end
    ph = a[23:12];
    ph = (ph * w[23:12]) % 3329;
    pl = a[11:0];
    pl = (pl * w[11:0]) % 3329;
    return {ph[11:0], pl[11:0]};
  endfunction

  // Drive one cycle of inputs; valid beats push their expected result and due cycle
  task automatic applyStimulus(input logic v, input logic mode, input logic byp,
                               input logic [23:0] a, input logic [23:0] w);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid = v;
    KD_mode  = mode;
    bypass   = byp;
    mul_a    = a;
    mul_w    = w;
    if (v) begin
      e.data = modelP(mode, byp, a, w);
      e.due  = cyc + 5;
      sb.push_back(e);
    end
  endtask

  // Compare outputs on the falling edge: data, alignment, and hold when idle
  task automatic checkOutput();
    exp_t e;
    if (out_valid) begin
      checks++;
      assert (sb.size() > 0)
        else begin errors++; $error("[TB] FAIL unexpected_valid observed 1 expected 0 at cycle %0d", cyc); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert (mul_p === e.data)
          else begin errors++; $error("[TB] FAIL mul_p observed %h expected %h", mul_p, e.data); end
        checks++;
        assert (cyc === e.due)
          else begin errors++; $error("[TB] FAIL latency observed cycle %0d expected %0d", cyc, e.due); end
        lastP = e.data;
      end
    end else begin
      checks++;
      assert (mul_p === lastP)
        else begin errors++; $error("[TB] FAIL hold observed %h expected %h", mul_p, lastP); end
      if (sb.size() > 0) begin
        checks++;
        assert (sb[0].due > cyc)
          else begin
            errors++;
            $error("[TB] FAIL missing_valid observed 0 expected 1 at cycle %0d", cyc);
            void'(sb.pop_front());
          end
      end
    end
  endtask

  always @(negedge clk) checkOutput();

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    KD_mode  = 1'b0;
    bypass   = 1'b0;
    mul_a    = '0;
    mul_w    = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    assert (out_valid === 1'b0 && mul_p === 24'h0)
      else begin errors++; $error("[TB] FAIL reset_state observed %b/%h expected 0/000000", out_valid, mul_p); end
    #1 rst = 1'b1;

    // Kyber lanes, then idle so the hold and single-cycle valid are observed
    applyStimulus(1, 0, 0, {12'd3328, 12'd17}, {12'd3328, 12'd1729});
    repeat (6) applyStimulus(0, 0, 0, '0, '0);

    // Dilithium back-to-back
    applyStimulus(1, 1, 0, 24'd8380416, 24'd8380416);
    applyStimulus(1, 1, 0, 24'd4194304, 24'd2);
    repeat (6) applyStimulus(0, 0, 0, '0, '0);

    // Mode interleave every cycle
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) applyStimulus(1, 0, 0, {12'd3328, 12'd17}, {12'd3328, 12'd1729});
      else            applyStimulus(1, 1, 0, 24'd4194304, 24'd2);
    end
    repeat (6) applyStimulus(0, 0, 0, '0, '0);

    // Bypass in both modes, including a set bit 23
    applyStimulus(1, 0, 1, 24'h123ABC, 24'h000777);
    applyStimulus(1, 1, 1, 24'h123ABC, 24'h000777);
    applyStimulus(1, 1, 1, 24'hF23ABC, 24'h000001);
    applyStimulus(1, 0, 1, 24'hF23ABC, 24'h000001);
    repeat (6) applyStimulus(0, 0, 0, '0, '0);

    // Reset mid-stream: in-flight beats vanish, output returns to zero
    applyStimulus(1, 0, 0, {12'd100, 12'd200}, {12'd300, 12'd400});
    applyStimulus(1, 1, 0, 24'd1234567, 24'd7654321);
    applyStimulus(1, 0, 0, {12'd3000, 12'd5}, {12'd7, 12'd3300});
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    sb.delete();
    lastP    = '0;
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (6) applyStimulus(0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, {12'd3328, 12'd17}, {12'd3328, 12'd1729});
    repeat (6) applyStimulus(0, 0, 0, '0, '0);

    // Random sweep with random mode, bypass and valid gaps
    for (int i = 0; i < 3000; i++) begin
      logic        v, m, b;
      logic [23:0] a, w;
      v = ($urandom_range(9) < 8);
      m = $urandom_range(1);
      b = ($urandom_range(15) == 0);
      if (m) begin
        a = {1'($urandom_range(1)), 23'($urandom_range(8380416))};
        w = {1'($urandom_range(1)), 23'($urandom_range(8380416))};
      end else begin
        a = {12'($urandom_range(3328)), 12'($urandom_range(3328))};
        w = {12'($urandom_range(3328)), 12'($urandom_range(3328))};
      end
      applyStimulus(v, m, b, a, w);
    end
    applyStimulus(0, 0, 0, '0, '0);

    // Drain with a bounded wait
    for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    assert (sb.size() == 0)
      else begin errors++; $error("[TB] FAIL drain observed %0d pending expected 0", sb.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
